// File: rtl/multicycle_cpu_if.sv
// Instruction-fetch handshake between multicycle_cpu (master) and an external
// instruction memory (slave): req/valid with variable response latency.
interface multicycle_cpu_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic [PC_W-1:0]    instr_addr;
  logic               instr_req;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;

  modport master (
    output instr_addr,
    output instr_req,
    input  instr_valid,
    input  instruction
  );

  modport slave (
    input  instr_addr,
    input  instr_req,
    output instr_valid,
    output instruction
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle ADD/LW/SW/BEQ processor: FETCH/DECODE/EXEC/MEM/WB state machine,
// internal register file and data memory. Define MCPU_PERF_EN for cycle/retire counters.
module multicycle_cpu #(
  parameter int DATA_W    = 8,
  parameter int REG_CNT   = 4,
  parameter int MEM_DEPTH = 16,
  parameter int PC_W      = 8
) (
  input  logic                       clk_in,
  input  logic                       reset,
  multicycle_cpu_if.master           imem,
  output logic [PC_W-1:0]            pc,
  output logic [2:0]                 state,
  output logic                       wb_valid,
  output logic [$clog2(REG_CNT)-1:0] wb_reg,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       branch_taken,
  output logic                       retire
`ifdef MCPU_PERF_EN
  ,
  output logic [31:0]                cycle_cnt,
  output logic [31:0]                instr_cnt
`endif
);

  localparam int RA_W    = $clog2(REG_CNT);
  localparam int MA_W    = $clog2(MEM_DEPTH);
  localparam int INSTR_W = 2 + 3 * RA_W;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_BEQ = 2'b11
  } op_t;

  function automatic logic signed [DATA_W-1:0] sext_data(input logic [RA_W-1:0] v);
    return $signed({{(DATA_W - RA_W){v[RA_W-1]}}, v});
  endfunction

  function automatic logic signed [PC_W-1:0] sext_pc(input logic [RA_W-1:0] v);
    return $signed({{(PC_W - RA_W){v[RA_W-1]}}, v});
  endfunction

  state_t               st_q;
  logic [INSTR_W-1:0]   ir;
  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic [DATA_W-1:0]    alu;
  logic [DATA_W-1:0]    mdr;
  logic [DATA_W-1:0]    rf  [REG_CNT];
  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  op_t                   op;
  logic [RA_W-1:0]       rs;
  logic [RA_W-1:0]       rt;
  logic [RA_W-1:0]       rd;
  logic signed [DATA_W-1:0] imm_d;
  logic signed [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0]     alu_res;
  logic [MA_W-1:0]       maddr;
  logic [DATA_W-1:0]     mem_rd;
  logic [PC_W-1:0]       pc_inc;

  assign op      = op_t'(ir[INSTR_W-1 -: 2]);
  assign rs      = ir[3*RA_W-1 -: RA_W];
  assign rt      = ir[2*RA_W-1 -: RA_W];
  assign rd      = ir[RA_W-1:0];
  assign imm_d   = sext_data(rd);
  assign imm_pc  = sext_pc(rd);
  assign alu_res = a + ((op == OP_ADD) ? b : $unsigned(imm_d));
  assign maddr   = alu[MA_W-1:0];
  assign mem_rd  = mem[maddr];
  assign pc_inc  = pc + PC_W'(1);

  assign imem.instr_addr = pc;
  assign imem.instr_req  = (st_q == FETCH);
  assign state           = st_q;

  // Pulse outputs are set on the edge entering the state they describe,
  // so they are visible for exactly that one state cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      st_q         <= FETCH;
      pc           <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      alu          <= '0;
      mdr          <= '0;
      wb_valid     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      branch_taken <= 1'b0;
      retire       <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= DATA_W'(i);
    end else begin
      wb_valid     <= 1'b0;
      branch_taken <= 1'b0;
      retire       <= 1'b0;
      case (st_q)
        FETCH: begin
          if (imem.instr_valid) begin
            ir   <= imem.instruction;
            st_q <= DECODE;
          end
        end
        DECODE: begin
          a    <= rf[rs];
          b    <= rf[rt];
          st_q <= EXEC;
          if (op == OP_BEQ) begin
            retire       <= 1'b1;
            branch_taken <= (rf[rs] == rf[rt]);
          end
        end
        EXEC: begin
          alu <= alu_res;
          case (op)
            OP_ADD: begin
              wb_valid <= 1'b1;
              wb_reg   <= rd;
              wb_data  <= alu_res;
              retire   <= 1'b1;
              st_q     <= WB;
            end
            OP_LW: st_q <= MEM;
            OP_SW: begin
              retire <= 1'b1;
              st_q   <= MEM;
            end
            default: begin
              pc   <= (a == b) ? pc_inc + $unsigned(imm_pc) : pc_inc;
              st_q <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (op == OP_LW) begin
            mdr      <= mem_rd;
            wb_valid <= 1'b1;
            wb_reg   <= rt;
            wb_data  <= mem_rd;
            retire   <= 1'b1;
            st_q     <= WB;
          end else begin
            mem[maddr] <= b;
            pc         <= pc_inc;
            st_q       <= FETCH;
          end
        end
        WB: begin
          rf[wb_reg] <= (op == OP_LW) ? mdr : alu;
          pc         <= pc_inc;
          st_q       <= FETCH;
        end
        default: st_q <= FETCH;
      endcase
    end
  end

`ifdef MCPU_PERF_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multicycle successor to the 8-bit single-cycle teaching processor.
- Same four-opcode ISA (ADD / LW / SW / branch); branch is now conditional BEQ.
- A state machine splits execution into FETCH/DECODE/EXEC/MEM/WB.
- External instruction memory is accessed through a req/valid handshake with variable latency.
- Registers and data memory are internal; widths and depths are parametrised.

Parameters:
- DATA_W, 8: register, ALU and data memory word width.
- REG_CNT, 4: number of general registers, power of 2 ≥ 2. RA_W = clog2(REG_CNT).
- MEM_DEPTH, 16: data memory words, power of 2. MA_W = clog2(MEM_DEPTH).
- PC_W, 8: program counter width.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_addr  output  PC_W  instruction fetch address; always equals pc.
- instr_req  output  1  fetch request; high only in FETCH.
- instr_valid  input  1  instruction data valid; sampled only in FETCH.
- instruction  input  INSTR_W  INSTR_W = 2+3*RA_W (8 at defaults).
- pc  output  PC_W  current program counter.
- state  output  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- wb_valid  output  1  one-cycle pulse when a register is written.
- wb_reg  output  RA_W  register written this cycle.
- wb_data  output  DATA_W  value written this cycle.
- branch_taken  output  1  one-cycle pulse in EXEC when BEQ is taken.
- retire  output  1  one-cycle pulse on the last state of each instruction.

Behaviour:
- Instruction fields, MSB first: opcode[2], rs[RA_W], rt[RA_W], rd/imm[RA_W].
- imm is sign-extended from RA_W to DATA_W (or to PC_W for branch offsets).
- Opcodes:
  - 00 ADD: R[rd] = R[rs] + R[rt].
  - 01 LW: R[rt] = M[(R[rs] + imm) mod MEM_DEPTH].
  - 10 SW: M[(R[rs] + imm) mod MEM_DEPTH] = R[rt].
  - 11 BEQ: if R[rs] == R[rt], pc = pc + 1 + imm; else pc = pc + 1.
- Reset (reset low, asynchronous):
  - state=FETCH, pc=0, all registers 0, M[i] = i mod 2^DATA_W.
  - IR, A, B and ALU registers cleared.
  - wb_valid, wb_reg, wb_data, branch_taken and retire all 0.
  - instr_req=1 once reset is released.
- FETCH: instr_req=1. Hold state and pc until instr_valid=1, then latch instruction into IR and go to DECODE.
- DECODE: latch A = R[rs] and B = R[rt] → EXEC.
- EXEC: ALU = A + (ADD ? B : imm), modulo 2^DATA_W.
  - ADD → WB.
  - LW and SW → MEM.
  - BEQ: update pc, pulse retire, pulse branch_taken if taken → FETCH.
- MEM: address is the low MA_W bits of ALU.
  - LW: synchronous read into MDR → WB.
  - SW: write B at this edge, pc += 1, pulse retire → FETCH.
- WB: write R[dest] (dest = rd for ADD, rt for LW); pulse wb_valid and retire; pc += 1 → FETCH.
- Cycles per instruction with zero fetch wait: ADD 4, LW 5, SW 4, BEQ 3. Each fetch wait cycle adds 1.
- pc wraps modulo 2^PC_W, for both increment and branch.
- instr_valid outside FETCH is ignored. The instruction input is only sampled in the FETCH cycle where instr_valid=1.
- The register file is written only in WB and memory only in MEM, so there is no read/write hazard within an instruction.
- Register 0 is writable (not hardwired).
- Reset asserted in any state aborts the instruction: no pending register or memory write occurs, and every value returns to its reset state.
- Undefined state encodings 5-7 → FETCH on next edge.

Optional Feature:
- Macro MCPU_PERF_EN.
- When defined, adds outputs cycle_cnt[31:0] and instr_cnt[31:0]:
  - cycle_cnt increments every cycle after reset.
  - instr_cnt increments on retire.
  - Both clear on reset and wrap at 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then instruction 8'b01_00_01_01 (LW r1,1(r0)) with instr_valid immediate → wb_valid with wb_reg=1, wb_data=1 in cycle 5; pc=1; retire once.
- Next, 8'b00_01_01_10 (ADD r2=r1+r1) → wb_reg=2, wb_data=2 after 4 cycles; pc=2.
- 8'b10_00_10_11 (SW r2,-1(r0)) → address 0xFF mod 16 = 15; M[15]=2; no wb_valid. A following LW r3,-1(r0) gives wb_data=2.
- At pc=4 with r1==r1, 8'b11_01_01_10 (BEQ imm=-2) → branch_taken pulse; pc = 4+1-2 = 3. With rs=r1, rt=r2 (1≠2) → no pulse; pc=5.
- Hold instr_valid low for 3 cycles in FETCH → instr_req stays 1; state=0; pc and registers unchanged. ADD then completes in 7 cycles total.
- Drive reset low during MEM of SW → M unchanged; pc=0; state=0; r1..r3=0. With MCPU_PERF_EN, cycle_cnt=0 and instr_cnt=0.
